sram_rr_arbiter: RTL and testbench

Parametrised N-channel arbiter that lets several SRAM-style masters (CPU instruction port, CPU data port, later DMA/debug) share one single-port synchronous SRAM. It sits between `mycpu_top`-class masters and the memory macro in the SoC top. It provides round-robin arbitration, an address/data handshake per channel and a configurable-latency read-return pipeline.

---
 rtl/sram_rr_arbiter_pkg.sv | 26 ++
 rtl/sram_rr_arbiter_rr_arbiter.sv | 50 +++++
 rtl/sram_rr_arbiter.sv | 114 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and helpers for the SRAM round-robin arbiter.
//                Holds the channel-id width helper and the tracking-entry
//                record carried through the read-return pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    // Widest channel id ever needed (up to 8 channels).
    localparam int C_MAX_CH_ID_W = 3;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_id_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    // One slot of the read-return tracking pipeline.
    typedef struct packed {
        logic                     valid;
        logic [C_MAX_CH_ID_W-1:0] ch_id;
    } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/sram_rr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Among the requesters, the
//                first one at or after the priority pointer wins. Produces a
//                one-hot grant, the grant index and an any-grant flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic            o_any
);

    int w_off;
    int w_best_off;
    int w_best_idx;

    // Pick the requester with the smallest circular distance from the pointer.
    always_comb begin
        w_best_off = N;
        w_best_idx = 0;
        w_off      = 0;
        for (int j = 0; j < N; j++) begin
            w_off = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
            if (i_req[j] && (w_off < w_best_off)) begin
                w_best_off = w_off;
                w_best_idx = j;
            end
        end
    end

    assign o_any       = (w_best_off < N);
    assign o_grant_idx = w_best_idx[ID_W-1:0];

    // Expand the winning index to a one-hot vector.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < N; j++) begin
            o_grant[j] = o_any && (w_best_idx == j);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rr_arbiter
//  Description : N-channel round-robin arbiter in front of a single-port
//                synchronous SRAM. Combinational grant, mux to the memory
//                side, RD_LAT-deep completion tracking and data_ok demux.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int N_CH    = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int RD_LAT  = 1,
    localparam int BE_W    = DATA_W / 8,
    localparam int CH_ID_W = ch_id_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*BE_W-1:0]     ch_wen,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_addr_ok,
    output logic [N_CH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]        ch_rdata,
    input  logic                     mem_ready,
    output logic                     mem_en,
    output logic [BE_W-1:0]          mem_wen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    logic [CH_ID_W-1:0] r_ptr;
    logic [N_CH-1:0]    w_req_elig;
    logic [N_CH-1:0]    w_grant;
    logic [CH_ID_W-1:0] w_gidx;
    logic               w_any;
    trk_entry_t         w_trk_in;
    trk_entry_t         w_trk_out;
    trk_entry_t         r_trk [RD_LAT];

    // Nothing may be granted while the memory is busy or reset is held.
    assign w_req_elig = (mem_ready && !rst) ? ch_req : '0;

    rr_arbiter #(
        .N    (N_CH),
        .ID_W (CH_ID_W)
    ) u_rr_arbiter (
        .i_req       (w_req_elig),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign ch_addr_ok = w_grant;
    assign mem_en     = w_any;

    // Route the granted channel's fields to the memory; zero when idle.
    always_comb begin
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_grant[c]) begin
                mem_wen   = ch_wen[c*BE_W +: BE_W];
                mem_addr  = ch_addr[c*ADDR_W +: ADDR_W];
                mem_wdata = ch_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // Priority pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (int'(w_gidx) == N_CH - 1) ? '0 : (w_gidx + CH_ID_W'(1));
        end
    end

    assign w_trk_in.valid = w_any;
    assign w_trk_in.ch_id = C_MAX_CH_ID_W'(w_gidx);

    // Every accepted access is tracked for RD_LAT cycles; reset drops all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_trk[s] <= '0;
            end
        end else begin
            r_trk[0] <= w_trk_in;
            for (int s = 1; s < RD_LAT; s++) begin
                r_trk[s] <= r_trk[s-1];
            end
        end
    end

    assign w_trk_out = r_trk[RD_LAT-1];

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_data_ok
            assign ch_data_ok[c] = !rst && w_trk_out.valid && (int'(w_trk_out.ch_id) == c);
        end
    endgenerate

    // Return data is only exposed alongside a completion pulse.
    assign ch_rdata = (|ch_data_ok) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_rr_arbiter
//  Description : Self-checking bench. Instance A (2 ch, latency 1) covers
//                reset, contention and backpressure; instance B (2 ch,
//                latency 3) covers write-then-read; instance C (4 ch,
//                latency 4) covers fairness and reset while accesses fly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_rr_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic [1:0]  a_req, a_addr_ok, a_data_ok;
    logic [7:0]  a_wen;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wen;
    logic        a_mem_ready, a_mem_en;

    sram_rr_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .ch_req(a_req), .ch_wen(a_wen), .ch_addr(a_addr),
        .ch_wdata(a_wdata), .ch_addr_ok(a_addr_ok), .ch_data_ok(a_data_ok),
        .ch_rdata(a_rdata), .mem_ready(a_mem_ready), .mem_en(a_mem_en),
        .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata)
    );

    // ---------------- instance B ----------------
    logic [1:0]  b_req, b_addr_ok, b_data_ok;
    logic [7:0]  b_wen;
    logic [63:0] b_addr, b_wdata;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wen;
    logic        b_mem_ready, b_mem_en;

    sram_rr_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .ch_req(b_req), .ch_wen(b_wen), .ch_addr(b_addr),
        .ch_wdata(b_wdata), .ch_addr_ok(b_addr_ok), .ch_data_ok(b_data_ok),
        .ch_rdata(b_rdata), .mem_ready(b_mem_ready), .mem_en(b_mem_en),
        .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // ---------------- instance C ----------------
    logic [3:0]   c_req, c_addr_ok, c_data_ok;
    logic [15:0]  c_wen;
    logic [127:0] c_addr, c_wdata;
    logic [31:0]  c_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
    logic [3:0]   c_mem_wen;
    logic         c_mem_ready, c_mem_en;

    sram_rr_arbiter #(.N_CH(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(4)) dut_c (
        .clk(clk), .rst(rst), .ch_req(c_req), .ch_wen(c_wen), .ch_addr(c_addr),
        .ch_wdata(c_wdata), .ch_addr_ok(c_addr_ok), .ch_data_ok(c_data_ok),
        .ch_rdata(c_rdata), .mem_ready(c_mem_ready), .mem_en(c_mem_en),
        .mem_wen(c_mem_wen), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
        .mem_rdata(c_mem_rdata)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] b_s0, b_s1, b_s2;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = init_word(i);
            mem_b[i] = init_word(i);
        end
    end

    // Latency-1 read-only memory; garbage on the bus when not accessed.
    always @(posedge clk) begin
        if (a_mem_en) a_mem_rdata <= mem_a[a_mem_addr[7:2]];
        else          a_mem_rdata <= 32'hBAD0_BAD0;
    end

    // Latency-3 read/write memory (read returns the pre-write word).
    always @(posedge clk) begin
        if (b_mem_en) begin
            b_s0 <= mem_b[b_mem_addr[7:2]];
            for (int k = 0; k < 4; k++) begin
                if (b_mem_wen[k]) mem_b[b_mem_addr[7:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
            end
        end else begin
            b_s0 <= 32'hBAD0_BAD0;
        end
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end
    assign b_mem_rdata = b_s2;

    assign c_mem_rdata = 32'h5A5A_5A5A;

    // ---------------- checking ----------------
    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       ready;
        logic [3:0] req;
        logic [3:0] ok;
        logic [3:0] dok;
    } vec_t;

    vec_t va [16];
    vec_t vc [27];

    task automatic b_step(input int idx, input logic [1:0] req, input logic [7:0] wen,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] e_ok, input logic [3:0] e_mwen,
                          input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                          input logic [1:0] e_dok, input logic chk_rd,
                          input logic [31:0] e_rd);
        b_req = req; b_wen = wen; b_addr = addr; b_wdata = wdata;
        @(negedge clk);
        check("b_addr_ok", idx, 32'(b_addr_ok), 32'(e_ok));
        check("b_mem_wen", idx, 32'(b_mem_wen), 32'(e_mwen));
        check("b_mem_addr", idx, b_mem_addr, e_maddr);
        check("b_mem_wdata", idx, b_mem_wdata, e_mwdata);
        check("b_data_ok", idx, 32'(b_data_ok), 32'(e_dok));
        if (chk_rd) check("b_rdata", idx, b_rdata, e_rd);
        @(posedge clk); #1;
    endtask

    logic [31:0] e_addr, e_wdata, e_rdata;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        a_req = '0; a_wen = '0; a_mem_ready = 1'b1;
        a_addr  = {32'h0000_0024, 32'h0000_0010};
        a_wdata = {32'h2222_2222, 32'h1111_1111};
        b_req = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_mem_ready = 1'b1;
        c_req = '0; c_wen = '0; c_addr = '0; c_wdata = '0; c_mem_ready = 1'b1;

        // {rst, mem_ready, req, expected addr_ok, expected data_ok}
        va[0]  = '{1'b1, 1'b1, 4'b01, 4'b00, 4'b00};
        va[1]  = '{1'b1, 1'b1, 4'b01, 4'b00, 4'b00};
        va[2]  = '{1'b0, 1'b1, 4'b01, 4'b01, 4'b00};
        va[3]  = '{1'b0, 1'b1, 4'b11, 4'b10, 4'b01};
        va[4]  = '{1'b0, 1'b1, 4'b11, 4'b01, 4'b10};
        va[5]  = '{1'b0, 1'b1, 4'b11, 4'b10, 4'b01};
        va[6]  = '{1'b0, 1'b0, 4'b11, 4'b00, 4'b10};
        va[7]  = '{1'b0, 1'b0, 4'b11, 4'b00, 4'b00};
        va[8]  = '{1'b0, 1'b0, 4'b11, 4'b00, 4'b00};
        va[9]  = '{1'b0, 1'b0, 4'b11, 4'b00, 4'b00};
        va[10] = '{1'b0, 1'b0, 4'b11, 4'b00, 4'b00};
        va[11] = '{1'b0, 1'b1, 4'b11, 4'b01, 4'b00};
        va[12] = '{1'b0, 1'b1, 4'b10, 4'b10, 4'b01};
        va[13] = '{1'b0, 1'b1, 4'b10, 4'b10, 4'b10};
        va[14] = '{1'b0, 1'b1, 4'b00, 4'b00, 4'b10};
        va[15] = '{1'b0, 1'b1, 4'b00, 4'b00, 4'b00};

        // Fairness over four channels, then channel 2 drops out, then drain,
        // then three reads cut short by a one-cycle reset.
        vc[0]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0000};
        vc[1]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 4'b0000};
        vc[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0000};
        vc[3]  = '{1'b0, 1'b1, 4'b1111, 4'b1000, 4'b0000};
        vc[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0001};
        vc[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0010, 4'b0010};
        vc[6]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100};
        vc[7]  = '{1'b0, 1'b1, 4'b1111, 4'b1000, 4'b1000};
        vc[8]  = '{1'b0, 1'b1, 4'b1011, 4'b0001, 4'b0001};
        vc[9]  = '{1'b0, 1'b1, 4'b1011, 4'b0010, 4'b0010};
        vc[10] = '{1'b0, 1'b1, 4'b1011, 4'b1000, 4'b0100};
        vc[11] = '{1'b0, 1'b1, 4'b1011, 4'b0001, 4'b1000};
        vc[12] = '{1'b0, 1'b1, 4'b1011, 4'b0010, 4'b0001};
        vc[13] = '{1'b0, 1'b1, 4'b1011, 4'b1000, 4'b0010};
        vc[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000};
        vc[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001};
        vc[16] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0010};
        vc[17] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1000};
        vc[18] = '{1'b0, 1'b1, 4'b1100, 4'b0100, 4'b0000};
        vc[19] = '{1'b0, 1'b1, 4'b1100, 4'b1000, 4'b0000};
        vc[20] = '{1'b0, 1'b1, 4'b1100, 4'b0100, 4'b0000};
        vc[21] = '{1'b1, 1'b1, 4'b1100, 4'b0000, 4'b0000};
        vc[22] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        vc[23] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        vc[24] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        vc[25] = '{1'b0, 1'b1, 4'b1100, 4'b0100, 4'b0000};
        vc[26] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000};

        // ---- instance A: reset, contention, backpressure, single requester
        for (int i = 0; i < 16; i++) begin
            rst = va[i].rst; a_mem_ready = va[i].ready; a_req = va[i].req[1:0];
            e_addr  = (va[i].ok[1:0] == 2'b01) ? 32'h10 : (va[i].ok[1:0] == 2'b10) ? 32'h24 : 32'h0;
            e_wdata = (va[i].ok[1:0] == 2'b01) ? 32'h1111_1111 :
                      (va[i].ok[1:0] == 2'b10) ? 32'h2222_2222 : 32'h0;
            e_rdata = (va[i].dok[1:0] == 2'b01) ? init_word(4) :
                      (va[i].dok[1:0] == 2'b10) ? init_word(9) : 32'h0;
            @(negedge clk);
            check("a_addr_ok", i, 32'(a_addr_ok), 32'(va[i].ok[1:0]));
            check("a_data_ok", i, 32'(a_data_ok), 32'(va[i].dok[1:0]));
            check("a_mem_en", i, 32'(a_mem_en), 32'(|va[i].ok));
            check("a_mem_addr", i, a_mem_addr, e_addr);
            check("a_mem_wdata", i, a_mem_wdata, e_wdata);
            check("a_mem_wen", i, 32'(a_mem_wen), 32'h0);
            check("a_rdata", i, a_rdata, e_rdata);
            @(posedge clk); #1;
        end
        a_req = '0;

        // ---- instance B: write 0xDEADBEEF, read back, partial write, read back
        b_step(0, 2'b10, 8'hF0, 64'h0000_0040_0000_0000, 64'hDEAD_BEEF_0000_0000,
               2'b10, 4'hF, 32'h40, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h0);
        b_step(1, 2'b10, 8'h00, 64'h0000_0040_0000_0000, 64'h0,
               2'b10, 4'h0, 32'h40, 32'h0, 2'b00, 1'b1, 32'h0);
        b_step(2, 2'b01, 8'h03, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_1234,
               2'b01, 4'h3, 32'h40, 32'h0000_1234, 2'b00, 1'b1, 32'h0);
        b_step(3, 2'b01, 8'h00, 64'h0000_0000_0000_0040, 64'h0,
               2'b01, 4'h0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h0);
        b_step(4, 2'b00, 8'h00, 64'h0, 64'h0,
               2'b00, 4'h0, 32'h0, 32'h0, 2'b10, 1'b1, 32'hDEAD_BEEF);
        b_step(5, 2'b00, 8'h00, 64'h0, 64'h0,
               2'b00, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0, 32'h0);
        b_step(6, 2'b00, 8'h00, 64'h0, 64'h0,
               2'b00, 4'h0, 32'h0, 32'h0, 2'b01, 1'b1, 32'hDEAD_1234);
        b_step(7, 2'b00, 8'h00, 64'h0, 64'h0,
               2'b00, 4'h0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0);

        // ---- instance C: fairness and reset with accesses in flight
        for (int i = 0; i < 27; i++) begin
            rst = vc[i].rst; c_mem_ready = vc[i].ready; c_req = vc[i].req;
            @(negedge clk);
            check("c_addr_ok", i, 32'(c_addr_ok), 32'(vc[i].ok));
            check("c_data_ok", i, 32'(c_data_ok), 32'(vc[i].dok));
            check("c_mem_en", i, 32'(c_mem_en), 32'(|vc[i].ok));
            check("c_rdata", i, c_rdata, (|vc[i].dok) ? 32'h5A5A_5A5A : 32'h0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
